// File: rtl/litepcie_us_rc_pkg.sv
// -----------------------------------------------------------------------------
// litepcie_us_rc_pkg
// Shared definitions for the UltraScale RC completion adapter:
//   - fmt/type codes for the four completion flavours
//   - bit offsets of the fields in the Xilinx RC descriptor (first beat)
//   - helpers that rebuild a legacy 4DW completion header from a descriptor
// -----------------------------------------------------------------------------
package litepcie_us_rc_pkg;

    // {fmt[2:0], type[4:0]} of the rebuilt completion header
    typedef enum logic [7:0] {
        FT_CPL    = 8'h0A,
        FT_CPLD   = 8'h4A,
        FT_CPLLK  = 8'h0B,
        FT_CPLDLK = 8'h4B
    } cpl_fmt_type_e;

    // RC descriptor field positions
    localparam int RC_LOWADDR_LSB = 0;
    localparam int RC_LOWADDR_W   = 7;
    localparam int RC_BYTECNT_LSB = 16;
    localparam int RC_BYTECNT_W   = 12;
    localparam int RC_LOCKED_BIT  = 29;
    localparam int RC_DWLEN_LSB   = 32;
    localparam int RC_DWLEN_W     = 10;
    localparam int RC_STATUS_LSB  = 43;
    localparam int RC_STATUS_W    = 3;
    localparam int RC_POISON_BIT  = 46;
    localparam int RC_REQID_LSB   = 48;
    localparam int RC_TAG_LSB     = 64;
    localparam int RC_CPLID_LSB   = 72;
    localparam int RC_TC_LSB      = 89;
    localparam int RC_ATTR_LSB    = 92;

    // Output sideband and the header span the SOP keep always covers
    localparam int OUT_USER_WIDTH = 85;
    localparam int HDR_WIDTH      = 128;
    localparam int SOP_KEEP_BYTES = 12;

    function automatic cpl_fmt_type_e cpl_fmt_type(input logic locked,
                                                   input logic no_data);
        cpl_fmt_type_e ft;
        if (locked) begin
            if (no_data) ft = FT_CPLLK;
            else         ft = FT_CPLDLK;
        end else begin
            if (no_data) ft = FT_CPL;
            else         ft = FT_CPLD;
        end
        return ft;
    endfunction

    // Rebuild DW0..DW2 of a completion header; DW3 is passed through.
    function automatic logic [HDR_WIDTH-1:0] build_cpl_hdr(input logic [HDR_WIDTH-1:0] d);
        logic [HDR_WIDTH-1:0] h;
        logic [7:0]           ft;
        ft = cpl_fmt_type(d[RC_LOCKED_BIT],
                          d[RC_BYTECNT_LSB +: RC_BYTECNT_W] == '0);
        h = d;
        // DW0: fmt/type, tc, td/ep forced to 0, attr, length
        h[31:0]  = {ft, 1'b0, d[RC_TC_LSB +: 3], 4'b0000, 2'b00,
                    d[RC_ATTR_LSB +: 2], 2'b00, d[RC_DWLEN_LSB +: RC_DWLEN_W]};
        // DW1: completer id, status, bcm=0, byte count
        h[63:32] = {d[RC_CPLID_LSB +: 16], d[RC_STATUS_LSB +: RC_STATUS_W], 1'b0,
                    d[RC_BYTECNT_LSB +: RC_BYTECNT_W]};
        // DW2: requester id, tag, lower address
        h[95:64] = {d[RC_REQID_LSB +: 16], d[RC_TAG_LSB +: 8], 1'b0,
                    d[RC_LOWADDR_LSB +: RC_LOWADDR_W]};
        return h;
    endfunction

endpackage

// File: rtl/m_axis_rc_adapt_pipe_skid.sv
// -----------------------------------------------------------------------------
// axis_skid2
// Two-entry (main + skid) AXI-stream register slice. Every output, including
// in_ready, comes straight from a flop.
//   clk, reset         : clock, synchronous active-high reset
//   in_data/valid/ready: upstream side, in_ready = skid entry empty
//   out_data/valid/ready: downstream side, driven from the main entry
// -----------------------------------------------------------------------------
module axis_skid2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;

    logic [WIDTH-1:0] main_data_d;
    logic             main_valid_d;
    logic [WIDTH-1:0] skid_data_d;
    logic             skid_valid_d;
    logic             push;
    logic             pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        main_data_d  = out_data;
        main_valid_d = out_valid;
        skid_data_d  = skid_data;
        skid_valid_d = skid_valid;
        if (!out_valid || pop) begin
            // Main is free this cycle: refill from skid first to keep order.
            // in_ready is low whenever skid is occupied, so push cannot
            // coincide with the skid-to-main move.
            if (skid_valid) begin
                main_data_d  = skid_data;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (push) begin
                main_data_d  = in_data;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (push) begin
            skid_data_d  = in_data;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            out_data   <= main_data_d;
            out_valid  <= main_valid_d;
            skid_data  <= skid_data_d;
            skid_valid <= skid_valid_d;
            in_ready   <= !skid_valid_d;
        end
    end

endmodule

// File: rtl/m_axis_rc_adapt_pipe.sv
// -----------------------------------------------------------------------------
// m_axis_rc_adapt_pipe
// Converts UltraScale RC completion beats into LitePCIe legacy-TLP beats,
// registered through a two-entry skid buffer.
//   user_clk, user_reset        : clock, synchronous active-high reset
//   m_axis_rc_*_a               : RC input stream (tkeep_a is ignored)
//   m_axis_rc_t*                : TLP output stream, tuser = {.., err_fwd, ecrc_err}
//   cpl_count                   : completions closed at the input (wraps)
//   cpl_err_pulse               : closed completion was poisoned/discontinued
// -----------------------------------------------------------------------------
module m_axis_rc_adapt_pipe
    import litepcie_us_rc_pkg::*;
#(
    parameter int DATA_WIDTH   = 256,
    parameter int KEEP_WIDTH   = DATA_WIDTH/8,
    parameter int USER_WIDTH_A = 75,
    parameter int DISC_BIT     = 42,
    parameter int BE_LSB       = 0
) (
    input  logic                      user_clk,
    input  logic                      user_reset,
    input  logic [DATA_WIDTH-1:0]     m_axis_rc_tdata_a,
    input  logic [DATA_WIDTH/32-1:0]  m_axis_rc_tkeep_a,
    input  logic                      m_axis_rc_tlast_a,
    input  logic [USER_WIDTH_A-1:0]   m_axis_rc_tuser_a,
    input  logic                      m_axis_rc_tvalid_a,
    output logic                      m_axis_rc_tready_a,
    output logic [DATA_WIDTH-1:0]     m_axis_rc_tdata,
    output logic [KEEP_WIDTH-1:0]     m_axis_rc_tkeep,
    output logic                      m_axis_rc_tlast,
    output logic [OUT_USER_WIDTH-1:0] m_axis_rc_tuser,
    output logic                      m_axis_rc_tvalid,
    input  logic                      m_axis_rc_tready,
    output logic [31:0]               cpl_count,
    output logic                      cpl_err_pulse
);

    generate
        if (!(DATA_WIDTH == 128 || DATA_WIDTH == 256 || DATA_WIDTH == 512)) begin : g_bad_width
            $error("m_axis_rc_adapt_pipe: DATA_WIDTH must be 128, 256 or 512");
        end
        if (BE_LSB + KEEP_WIDTH > USER_WIDTH_A || DISC_BIT >= USER_WIDTH_A) begin : g_bad_user
            $error("m_axis_rc_adapt_pipe: tuser fields fall outside USER_WIDTH_A");
        end
    endgenerate

    localparam int PAY_W = DATA_WIDTH + KEEP_WIDTH + 1 + OUT_USER_WIDTH;

    logic [1:0]                cnt;
    logic                      poison_q;
    logic                      err_sticky;
    logic                      hs_in;
    logic                      sop;
    logic                      poison_in;
    logic                      disc_in;
    logic                      err_fwd;
    logic                      err_now;
    logic [DATA_WIDTH-1:0]     conv_data;
    logic [KEEP_WIDTH-1:0]     conv_keep;
    logic [OUT_USER_WIDTH-1:0] conv_user;
    logic [PAY_W-1:0]          skid_in;
    logic [PAY_W-1:0]          skid_out;
    logic                      unused_in;

    // tkeep_a and the remaining tuser_a bits carry nothing we need
    assign unused_in = ^{m_axis_rc_tkeep_a, m_axis_rc_tuser_a};

    assign hs_in     = m_axis_rc_tvalid_a && m_axis_rc_tready_a;
    assign sop       = (cnt == 2'd0);
    assign poison_in = m_axis_rc_tdata_a[RC_POISON_BIT];
    assign disc_in   = m_axis_rc_tuser_a[DISC_BIT];
    // Poison only exists in the descriptor; bit 46 of later beats is payload.
    assign err_fwd   = sop ? poison_in : poison_q;
    assign err_now   = err_sticky | disc_in | (sop & poison_in);

    always_comb begin
        conv_data = m_axis_rc_tdata_a;
        conv_keep = m_axis_rc_tuser_a[BE_LSB +: KEEP_WIDTH];
        if (sop) begin
            conv_data[HDR_WIDTH-1:0]      = build_cpl_hdr(m_axis_rc_tdata_a[HDR_WIDTH-1:0]);
            conv_keep[SOP_KEEP_BYTES-1:0] = '1;
        end
    end

    assign conv_user = {{(OUT_USER_WIDTH-2){1'b0}}, err_fwd, disc_in};
    assign skid_in   = {conv_data, conv_keep, m_axis_rc_tlast_a, conv_user};

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            cnt           <= 2'd0;
            poison_q      <= 1'b0;
            err_sticky    <= 1'b0;
            cpl_count     <= 32'd0;
            cpl_err_pulse <= 1'b0;
        end else begin
            cpl_err_pulse <= 1'b0;
            if (hs_in) begin
                if (sop) begin
                    poison_q <= poison_in;
                end
                if (m_axis_rc_tlast_a) begin
                    cnt           <= 2'd0;
                    err_sticky    <= 1'b0;
                    cpl_count     <= cpl_count + 32'd1;
                    cpl_err_pulse <= err_now;
                end else begin
                    err_sticky <= err_now;
                    if (cnt != 2'd2) begin
                        cnt <= cnt + 2'd1;
                    end
                end
            end
        end
    end

    axis_skid2 #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clk       (user_clk),
        .reset     (user_reset),
        .in_data   (skid_in),
        .in_valid  (m_axis_rc_tvalid_a),
        .in_ready  (m_axis_rc_tready_a),
        .out_data  (skid_out),
        .out_valid (m_axis_rc_tvalid),
        .out_ready (m_axis_rc_tready)
    );

    assign {m_axis_rc_tdata, m_axis_rc_tkeep, m_axis_rc_tlast, m_axis_rc_tuser} = skid_out;

endmodule
